// File: rtl/flt2int_pkg.sv
// Shared types and constants for the sequential float-to-integer converter.
package flt2int_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_UNPACK = 3'd2,
        S_SHIFT  = 3'd3,
        S_ROUND  = 3'd4,
        S_WR     = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    localparam logic RM_TRUNC = 1'b0;
    localparam logic RM_RNE   = 1'b1;

    // Largest positive two's-complement value of width w.
    function automatic logic [63:0] max_pos(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement pattern of width w; also its magnitude.
    function automatic logic [63:0] min_neg(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/flt_shift_round.sv
// Bit-serial significand shifter: aligns the binary point one bit per step and
// collects guard/sticky bits for the rounding stage.
module flt_shift_round
    import flt2int_pkg::*;
#(
    parameter int unsigned MAN_W = 10,
    parameter int unsigned INT_W = 16,
    parameter int unsigned SH_W  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 left_i,
    input  logic [MAN_W:0]       sig_i,
    input  logic [SH_W-1:0]      shamt_i,
    output logic                 done_shift_o,
    output logic [INT_W+MAN_W:0] mag_o,
    output logic                 guard_o,
    output logic                 sticky_o
);

    localparam int unsigned WK_W = INT_W + MAN_W + 1;

    logic [WK_W-1:0] wk_q, wk_d;
    logic [SH_W-1:0] cnt_q, cnt_d;
    logic            left_q, left_d;
    logic            guard_q, guard_d;
    logic            sticky_q, sticky_d;
    logic            done_q, done_d;

    always_comb begin
        wk_d     = wk_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        done_d   = done_q;
        if (load_i) begin
            wk_d     = WK_W'(sig_i);
            cnt_d    = shamt_i;
            left_d   = left_i;
            guard_d  = 1'b0;
            sticky_d = 1'b0;
            done_d   = (shamt_i == '0);
        end else if (step_i && !done_q) begin
            wk_d   = left_q ? (wk_q << 1) : (wk_q >> 1);
            // Right shifts push the dropped bit into guard and age guard into sticky
            if (!left_q) begin
                guard_d  = wk_q[0];
                sticky_d = sticky_q | guard_q;
            end
            cnt_d  = cnt_q - SH_W'(1);
            done_d = (cnt_q == SH_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wk_q     <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wk_q     <= wk_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            done_q   <= done_d;
        end
    end

    assign done_shift_o = done_q;
    assign mag_o        = wk_q;
    assign guard_o      = guard_q;
    assign sticky_o     = sticky_q;

endmodule

// File: rtl/flt2int_seq.sv
// Multi-cycle float-to-signed-integer converter: reads a packed float from byte
// memory, converts with truncate or round-to-nearest-even, writes the result back.
module flt2int_seq
    import flt2int_pkg::*;
#(
    parameter int unsigned EXP_W    = 5,
    parameter int unsigned MAN_W    = 10,
    parameter int unsigned BIAS     = 15,
    parameter int unsigned INT_W    = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned SRC_ADDR = 4,
    parameter int unsigned DST_ADDR = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              round_mode,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              flag_ovf,
    output logic              flag_inexact,
    output logic              flag_invalid
);

    localparam int unsigned FLT_W  = 1 + EXP_W + MAN_W;
    localparam int unsigned FLT_B  = FLT_W / 8;
    localparam int unsigned INT_B  = INT_W / 8;
    localparam int unsigned WK_W   = INT_W + MAN_W + 1;
    localparam int unsigned MG_W   = WK_W + 1;
    localparam int unsigned MAX_SH = (MAN_W + 1 > INT_W) ? MAN_W + 1 : INT_W;
    localparam int unsigned SH_W   = $clog2(MAX_SH + 1);
    localparam int unsigned MAX_B  = (FLT_B > INT_B) ? FLT_B : INT_B;
    localparam int unsigned CNT_W  = $clog2(MAX_B + 1);
    localparam logic [INT_W-1:0] MAX_POS = INT_W'(max_pos(INT_W));
    localparam logic [INT_W-1:0] MIN_NEG = INT_W'(min_neg(INT_W));

    state_e            state_q, state_d;
    logic              start_q;
    logic              rm_q, rm_d;
    logic [FLT_W-1:0]  flt_q, flt_d;
    logic [INT_W-1:0]  res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, inex_q, inex_d, inv_q, inv_d;
    logic              done_q, done_d, busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wdata_q, wdata_d;

    logic [EXP_W-1:0]  exp_c;
    logic [MAN_W-1:0]  man_c;
    logic              sign_c;
    logic [MAN_W:0]    sig_c;
    int                unb_e_c;
    logic              nan_c, inf_c, big_c, tiny_c, left_c;
    logic [SH_W-1:0]   shamt_c;

    logic              done_shift;
    logic [WK_W-1:0]   mag;
    logic              guard, sticky;
    logic              rnd_up_c;
    logic [MG_W-1:0]   mag_rnd_c;

    // Field decode and classification of the captured float
    always_comb begin
        sign_c  = flt_q[FLT_W-1];
        exp_c   = flt_q[FLT_W-2 -: EXP_W];
        man_c   = flt_q[MAN_W-1:0];
        sig_c   = {|exp_c, man_c};
        unb_e_c = (exp_c == '0) ? 1 - int'(BIAS) : int'(exp_c) - int'(BIAS);
        nan_c   = (&exp_c) && (|man_c);
        inf_c   = (&exp_c) && !(|man_c);
        big_c   = unb_e_c >= int'(INT_W);
        tiny_c  = unb_e_c < -1;
        left_c  = unb_e_c >= int'(MAN_W);
        shamt_c = left_c ? SH_W'(unb_e_c - int'(MAN_W)) : SH_W'(int'(MAN_W) - unb_e_c);
    end

    flt_shift_round #(
        .MAN_W (MAN_W),
        .INT_W (INT_W),
        .SH_W  (SH_W)
    ) u_shift (
        .clk          (clk),
        .reset        (reset),
        .load_i       (state_q == S_UNPACK),
        .step_i       (state_q == S_SHIFT),
        .left_i       (left_c),
        .sig_i        (sig_c),
        .shamt_i      (shamt_c),
        .done_shift_o (done_shift),
        .mag_o        (mag),
        .guard_o      (guard),
        .sticky_o     (sticky)
    );

    always_comb begin
        rnd_up_c  = (rm_q == RM_RNE) && guard && (mag[0] || sticky);
        mag_rnd_c = MG_W'(mag) + MG_W'(rnd_up_c);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a falling edge of start launches an operation
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!start && start_q) state_d = S_RD;
            S_RD:     if (cnt_q == CNT_W'(FLT_B)) state_d = S_UNPACK;
            S_UNPACK: state_d = (nan_c || inf_c || big_c || tiny_c) ? S_WR : S_SHIFT;
            S_SHIFT:  if (done_shift) state_d = S_ROUND;
            S_ROUND:  state_d = S_WR;
            S_WR:     if (cnt_q == CNT_W'(INT_B - 1)) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values, aligned so registered outputs match state_q
    always_comb begin
        rm_d    = rm_q;
        flt_d   = flt_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        inex_d  = inex_q;
        inv_d   = inv_q;
        addr_d  = addr_q;
        wr_en_d = 1'b0;
        wdata_d = wdata_q;
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == S_RD || state_q == S_WR) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (state_d == S_RD) begin
                    rm_d   = round_mode ? RM_RNE : RM_TRUNC;
                    ovf_d  = 1'b0;
                    inex_d = 1'b0;
                    inv_d  = 1'b0;
                end
            end
            S_RD: begin
                // Bytes arrive low first; shifting in from the top leaves byte k at [8k+7:8k]
                if (cnt_q != '0) flt_d = FLT_W'({mem_rdata, flt_q} >> 8);
            end
            S_UNPACK: begin
                if (nan_c) begin
                    res_d = '0;
                    inv_d = 1'b1;
                end else if (inf_c || big_c) begin
                    res_d = sign_c ? MIN_NEG : MAX_POS;
                    ovf_d = 1'b1;
                end else if (tiny_c) begin
                    res_d  = '0;
                    inex_d = |sig_c;
                end
            end
            S_ROUND: begin
                inex_d = guard | sticky;
                if (!sign_c && mag_rnd_c > MG_W'(MAX_POS)) begin
                    res_d = MAX_POS;
                    ovf_d = 1'b1;
                end else if (sign_c && mag_rnd_c > MG_W'(MIN_NEG)) begin
                    res_d = MIN_NEG;
                    ovf_d = 1'b1;
                end else begin
                    res_d = sign_c ? INT_W'(-mag_rnd_c) : INT_W'(mag_rnd_c);
                end
            end
            default: ;
        endcase

        if (state_d == S_RD && cnt_d < CNT_W'(FLT_B)) begin
            addr_d = ADDR_W'(SRC_ADDR) + ADDR_W'(cnt_d);
        end
        if (state_d == S_WR) begin
            addr_d  = ADDR_W'(DST_ADDR) + ADDR_W'(cnt_d);
            wr_en_d = 1'b1;
            wdata_d = 8'(res_d >> {cnt_d, 3'b000});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= 1'b0;
            rm_q    <= RM_TRUNC;
            flt_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            inex_q  <= 1'b0;
            inv_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            wr_en_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            start_q <= start;
            rm_q    <= rm_d;
            flt_q   <= flt_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            inex_q  <= inex_d;
            inv_q   <= inv_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            wr_en_q <= wr_en_d;
            wdata_q <= wdata_d;
        end
    end

    assign done         = done_q;
    assign busy         = busy_q;
    assign mem_addr     = addr_q;
    assign mem_wr_en    = wr_en_q;
    assign mem_wdata    = wdata_q;
    assign flag_ovf     = ovf_q;
    assign flag_inexact = inex_q;
    assign flag_invalid = inv_q;

endmodule

// File: tb/tb_flt2int_seq.sv
// Bench for flt2int_seq: byte memory model plus a real-arithmetic reference.
module tb_flt2int_seq;

    localparam int LAT_MAX = 2 + 16 + 2 + 5;

    typedef struct packed {
        logic [15:0] f;
        logic        rm;
        logic [15:0] res;
        logic        ovf;
        logic        inex;
        logic        inv;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, start, round_mode;
    logic       done, busy, mem_wr_en;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       flag_ovf, flag_inexact, flag_invalid;

    logic [7:0]  mem [256];
    logic        ld_en = 1'b0;
    logic [15:0] ld_word = 16'h0;
    int          wr_count = 0;
    int          wr_bad = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    flt2int_seq dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .round_mode   (round_mode),
        .done         (done),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .flag_ovf     (flag_ovf),
        .flag_inexact (flag_inexact),
        .flag_invalid (flag_invalid)
    );

    // Synchronous-read byte memory; loads the source float and fills the destination with 0xAA
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
            if (mem_addr != 8'd6 && mem_addr != 8'd7) wr_bad <= wr_bad + 1;
        end else if (ld_en) begin
            mem[4]   <= ld_word[7:0];
            mem[5]   <= ld_word[15:8];
            mem[6]   <= 8'hAA;
            mem[7]   <= 8'hAA;
            wr_count <= 0;
            wr_bad   <= 0;
        end
    end

    // Reference: exact real value, then truncate / round-half-even, then clamp
    function automatic void ref_conv(input logic [15:0] f, input logic rm, output logic [15:0] r,
                                     output logic ovf, output logic inex, output logic inv);
        int  ex, man, p, t;
        real a, frac;
        ex = int'(f[14:10]);
        man = int'(f[9:0]);
        r = 16'h0; ovf = 1'b0; inex = 1'b0; inv = 1'b0;
        if (ex == 31) begin
            if (man != 0) inv = 1'b1;
            else begin ovf = 1'b1; r = f[15] ? 16'h8000 : 16'h7FFF; end
            return;
        end
        if (ex == 0) begin a = $itor(man); p = -24; end
        else begin a = $itor(1024 + man); p = ex - 25; end
        while (p > 0) begin a = a * 2.0; p--; end
        while (p < 0) begin a = a / 2.0; p++; end
        t = $rtoi(a);
        frac = a - $itor(t);
        inex = (frac != 0.0);
        if (rm && (frac > 0.5 || (frac == 0.5 && t[0]))) t++;
        if (!f[15] && t > 32767) begin r = 16'h7FFF; ovf = 1'b1; end
        else if (f[15] && t > 32768) begin r = 16'h8000; ovf = 1'b1; end
        else r = f[15] ? 16'(-t) : 16'(t);
    endfunction

    task automatic run_op(input logic [15:0] f, input logic rm, input bit inject,
                          output logic [15:0] res, output logic [2:0] flg_done,
                          output logic [2:0] flg_end, output int lat, output int npulse,
                          output logic busy_end);
        ld_word = f;
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
        round_mode = rm;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        npulse = 0;
        flg_done = 3'b000;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) round_mode = ~rm;
            if (inject && n == 3) start = 1'b1;
            if (inject && n == 4) start = 1'b0;
            if (done) begin
                if (npulse == 0) begin
                    lat = n;
                    flg_done = {flag_ovf, flag_inexact, flag_invalid};
                end
                npulse++;
            end
        end
        res = {mem[7], mem[6]};
        flg_end = {flag_ovf, flag_inexact, flag_invalid};
        busy_end = busy;
    endtask

    task automatic test_reset();
        logic [21:0] got;
        reset = 1'b1;
        start = 1'b0;
        round_mode = 1'b0;
        repeat (3) @(negedge clk);
        got = {done, busy, mem_addr, mem_wr_en, mem_wdata, flag_ovf, flag_inexact, flag_invalid};
        n_tests++;
        if (got !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", got);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        vec_t        tab [15];
        logic [15:0] res;
        logic [2:0]  fd, fe, fx;
        int          lat, np;
        logic        be;
        tab = '{
            {16'h3C00, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0},
            {16'h4100, 1'b1, 16'h0002, 1'b0, 1'b1, 1'b0},
            {16'h4300, 1'b1, 16'h0004, 1'b0, 1'b1, 1'b0},
            {16'hC100, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0},
            {16'hC100, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0},
            {16'h3800, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0},
            {16'h3A00, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0},
            {16'h3A00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0},
            {16'h0001, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0},
            {16'h8000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0},
            {16'hF800, 1'b1, 16'h8000, 1'b0, 1'b0, 1'b0},
            {16'h7BFF, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0},
            {16'h7C00, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0},
            {16'hFC00, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0},
            {16'h7E00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1}
        };
        foreach (tab[i]) begin
            run_op(tab[i].f, tab[i].rm, 1'b0, res, fd, fe, lat, np, be);
            fx = {tab[i].ovf, tab[i].inex, tab[i].inv};
            n_tests++;
            if (res !== tab[i].res) begin
                n_fail++;
                $display("FAIL dir_result f=%h rm=%0b: got %h expected %h", tab[i].f, tab[i].rm, res, tab[i].res);
            end
            n_tests++;
            if (fd !== fx) begin
                n_fail++;
                $display("FAIL dir_flags_at_done f=%h: got %b expected %b", tab[i].f, fd, fx);
            end
            n_tests++;
            if (fe !== fx) begin
                n_fail++;
                $display("FAIL dir_flags_hold f=%h: got %b expected %b", tab[i].f, fe, fx);
            end
            n_tests++;
            if (np !== 1) begin
                n_fail++;
                $display("FAIL dir_done_pulse f=%h: got %0d cycles expected 1", tab[i].f, np);
            end
            n_tests++;
            if (lat < 1 || lat > LAT_MAX) begin
                n_fail++;
                $display("FAIL dir_latency f=%h: got %0d expected 1..%0d", tab[i].f, lat, LAT_MAX);
            end
            n_tests++;
            if (be !== 1'b0) begin
                n_fail++;
                $display("FAIL dir_busy_after f=%h: got %b expected 0", tab[i].f, be);
            end
            n_tests++;
            if (wr_count !== 2 || wr_bad !== 0) begin
                n_fail++;
                $display("FAIL dir_writes f=%h: got %0d writes (%0d stray) expected 2 (0 stray)", tab[i].f, wr_count, wr_bad);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] f, res, eres;
        logic        rm, eo, ei, ev, be;
        logic [2:0]  fd, fe;
        int          lat, np;
        for (int k = 0; k < 200; k++) begin
            f = 16'($urandom);
            rm = 1'($urandom);
            ref_conv(f, rm, eres, eo, ei, ev);
            run_op(f, rm, 1'b0, res, fd, fe, lat, np, be);
            n_tests++;
            if (res !== eres) begin
                n_fail++;
                $display("FAIL rand_result f=%h rm=%0b: got %h expected %h", f, rm, res, eres);
            end
            n_tests++;
            if (fd !== {eo, ei, ev}) begin
                n_fail++;
                $display("FAIL rand_flags f=%h rm=%0b: got %b expected %b", f, rm, fd, {eo, ei, ev});
            end
            n_tests++;
            if (np !== 1 || lat > LAT_MAX || lat < 1) begin
                n_fail++;
                $display("FAIL rand_done f=%h: got %0d pulses at %0d expected 1 within %0d", f, np, lat, LAT_MAX);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        int          seen;
        logic [21:0] got;
        logic [15:0] res;
        logic [2:0]  fd, fe;
        int          lat, np;
        logic        be;
        seen = 0;
        ld_word = 16'h3C00;
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
        round_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        got = {done, busy, mem_addr, mem_wr_en, mem_wdata, flag_ovf, flag_inexact, flag_invalid};
        n_tests++;
        if (got !== 22'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h expected 0", got);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy || mem_wr_en) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen);
        end
        n_tests++;
        if (wr_count !== 0 || {mem[7], mem[6]} !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL midreset_nowrite: got %0d writes, dst %h expected 0 writes, dst aaaa", wr_count, {mem[7], mem[6]});
        end
        run_op(16'h4300, 1'b1, 1'b0, res, fd, fe, lat, np, be);
        n_tests++;
        if (res !== 16'h0004 || np !== 1 || fd !== 3'b010) begin
            n_fail++;
            $display("FAIL midreset_recover: got %h pulses %0d flags %b expected 0004 pulses 1 flags 010", res, np, fd);
        end
    endtask

    task automatic test_start_while_busy();
        logic [15:0] res;
        logic [2:0]  fd, fe;
        int          lat, np;
        logic        be;
        run_op(16'h4300, 1'b1, 1'b1, res, fd, fe, lat, np, be);
        n_tests++;
        if (np !== 1) begin
            n_fail++;
            $display("FAIL busy_start_pulses: got %0d done pulses expected 1", np);
        end
        n_tests++;
        if (res !== 16'h0004 || wr_count !== 2) begin
            n_fail++;
            $display("FAIL busy_start_result: got %h with %0d writes expected 0004 with 2", res, wr_count);
        end
        n_tests++;
        if (be !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_idle: got busy %b expected 0", be);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_shift();
        test_start_while_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
